// File: rtl/soda_change_dispenser_pkg.sv
// Shared types and constants for the soda change dispenser.
// Optional coin counter is enabled by defining SODA_COIN_COUNT_EN.
package soda_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NICKEL  = 2'd0;
    localparam logic [1:0] COIN_DIME    = 2'd1;
    localparam logic [1:0] COIN_QUARTER = 2'd2;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_QUARTER = 25;
    localparam int DEF_DIME    = 10;
    localparam int DEF_NICKEL  = 5;

    localparam int COIN_CNT_W   = 5;

endpackage

// File: rtl/soda_change_dispenser_if.sv
// Request/coin-out bundle of the change dispenser.
// coin_cnt exists only when SODA_COIN_COUNT_EN is defined.
interface soda_change_dispenser_if
    import soda_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] tot;
    logic [WIDTH-1:0] s;
    logic             coin_rdy;
    logic             coin_vld;
    logic [1:0]       coin_sel;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] remainder;
`ifdef SODA_COIN_COUNT_EN
    logic [COIN_CNT_W-1:0] coin_cnt;
`endif

    // master: vend controller plus coin ejector; slave: the dispenser
    modport master (
        output start, tot, s, coin_rdy,
        input  coin_vld, coin_sel, busy, done, err, remainder
`ifdef SODA_COIN_COUNT_EN
        , input coin_cnt
`endif
    );

    modport slave (
        input  start, tot, s, coin_rdy,
        output coin_vld, coin_sel, busy, done, err, remainder
`ifdef SODA_COIN_COUNT_EN
        , output coin_cnt
`endif
    );

endinterface

// File: rtl/n_bit_adder.sv
// Ripple-carry adder primitive: sum = a + b + cin, with carry out.
module n_bit_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/n_bit_reg.sv
// Load-enabled register primitive with synchronous active-high clear.
module n_bit_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        always_ff @(posedge clk) begin
            if (srst) begin
                q[gi] <= 1'b0;
            end else if (en) begin
                q[gi] <= d[gi];
            end
        end
    end

endmodule

// File: rtl/soda_change_dispenser_coin_select.sv
// Greedy coin selector: largest coin not exceeding the change owed.
module soda_coin_select
    import soda_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int QUARTER = DEF_QUARTER,
    parameter int DIME    = DEF_DIME,
    parameter int NICKEL  = DEF_NICKEL
) (
    input  logic [WIDTH-1:0] chg,
    output logic [1:0]       coin_sel,
    output logic [WIDTH-1:0] coin_value
);
    localparam logic [WIDTH-1:0] QUARTER_V = WIDTH'(QUARTER);
    localparam logic [WIDTH-1:0] DIME_V    = WIDTH'(DIME);
    localparam logic [WIDTH-1:0] NICKEL_V  = WIDTH'(NICKEL);

    // Nickel is the fallback even below NICKEL; the FSM never issues it then.
    always_comb begin
        coin_sel   = COIN_NICKEL;
        coin_value = NICKEL_V;
        if (chg >= QUARTER_V) begin
            coin_sel   = COIN_QUARTER;
            coin_value = QUARTER_V;
        end else if (chg >= DIME_V) begin
            coin_sel   = COIN_DIME;
            coin_value = DIME_V;
        end
    end

endmodule

// File: rtl/soda_change_dispenser.sv
// Change-return controller: computes tot - s and ejects it coin by coin.
// Define SODA_COIN_COUNT_EN to add the per-transaction coin counter.
module soda_change_dispenser
    import soda_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int QUARTER = DEF_QUARTER,
    parameter int DIME    = DEF_DIME,
    parameter int NICKEL  = DEF_NICKEL
) (
    input  logic                   clk,
    input  logic                   rst,
    soda_change_dispenser_if.slave bus
);
    localparam logic [WIDTH-1:0] NICKEL_V = WIDTH'(NICKEL);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] chg_reg;
    logic             chg_load;
    logic [WIDTH-1:0] add_a, add_b, diff;
    logic             add_cout;
    logic [1:0]       sel;
    logic [WIDTH-1:0] coin_value;
    logic             coin_vld, busy, done;
    logic             xfer;
    logic             err_reg, err_next;

    soda_coin_select #(
        .WIDTH   (WIDTH),
        .QUARTER (QUARTER),
        .DIME    (DIME),
        .NICKEL  (NICKEL)
    ) u_select (
        .chg        (chg_reg),
        .coin_sel   (sel),
        .coin_value (coin_value)
    );

    // One subtractor serves both tot - s (IDLE) and chg - coin (ISSUE);
    // in IDLE its carry out doubles as the tot >= s compare.
    always_comb begin
        add_a = chg_reg;
        add_b = ~coin_value;
        if (state_reg == ST_IDLE) begin
            add_a = bus.tot;
            add_b = ~bus.s;
        end
    end

    n_bit_adder #(.N(WIDTH)) u_sub (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b1),
        .sum  (diff),
        .cout (add_cout)
    );

    assign xfer     = coin_vld & bus.coin_rdy;
    assign chg_load = ((state_reg == ST_IDLE) & bus.start & add_cout) | xfer;

    n_bit_reg #(.N(WIDTH)) u_chg (
        .clk  (clk),
        .srst (rst),
        .en   (chg_load),
        .d    (diff),
        .q    (chg_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    if (add_cout) begin
                        state_next = (diff == '0) ? ST_DONE : ST_ISSUE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (chg_reg < NICKEL_V) begin
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                end else if (xfer) begin
                    if (diff < NICKEL_V) begin
                        state_next = ST_DONE;
                        err_next   = (diff != '0);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A residue below a nickel at ISSUE entry is never offered as a coin.
    always_comb begin
        coin_vld = (state_reg == ST_ISSUE) & (chg_reg >= NICKEL_V);
        busy     = (state_reg != ST_IDLE);
        done     = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign bus.coin_vld  = coin_vld;
    assign bus.coin_sel  = coin_vld ? sel : COIN_NICKEL;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err_reg;
    assign bus.remainder = chg_reg;

`ifdef SODA_COIN_COUNT_EN
    logic [COIN_CNT_W-1:0] coin_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_cnt_reg <= '0;
        end else if ((state_reg == ST_IDLE) && bus.start && add_cout) begin
            coin_cnt_reg <= '0;
        end else if (xfer && (coin_cnt_reg != '1)) begin
            coin_cnt_reg <= coin_cnt_reg + 1'b1;
        end
    end

    assign bus.coin_cnt = coin_cnt_reg;
`endif

endmodule

// File: tb/tb_soda_change_dispenser.sv
// Directed bench for soda_change_dispenser; checks coin_cnt when
// SODA_COIN_COUNT_EN is defined.
module tb_soda_change_dispenser;
    import soda_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    soda_change_dispenser_if #(.WIDTH(8)) bus ();

    soda_change_dispenser #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [1:0] sel,
                           input logic bsy, input logic dn, input logic er,
                           input logic [7:0] rem);
        chk({tag, ".vld"}, 32'(bus.coin_vld), 32'(vld));
        if (vld) chk({tag, ".sel"}, 32'(bus.coin_sel), 32'(sel));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
        chk({tag, ".done"}, 32'(bus.done), 32'(dn));
        chk({tag, ".err"},  32'(bus.err),  32'(er));
        chk({tag, ".rem"},  32'(bus.remainder), 32'(rem));
        $display("%s vld=%0d sel=%0d busy=%0d done=%0d err=%0d rem=%0d", tag,
                 bus.coin_vld, bus.coin_sel, bus.busy, bus.done, bus.err, bus.remainder);
    endtask

    task automatic start_txn(input logic [7:0] t, input logic [7:0] p);
        bus.start = 1'b1;
        bus.tot   = t;
        bus.s     = p;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.tot      = '0;
        bus.s        = '0;
        bus.coin_rdy = 1'b1;
        step();
        step();
        chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset.sel", 32'(bus.coin_sel), 32'd0);
`ifdef SODA_COIN_COUNT_EN
        chk("reset.cnt", 32'(bus.coin_cnt), 32'd0);
`endif
        rst = 1'b0;
        step();

        // 75 - 50: one quarter
        start_txn(8'd75, 8'd50);
        chk_out("t75.c1", 1'b1, COIN_QUARTER, 1'b1, 1'b0, 1'b0, 8'd25);
        step();
        chk_out("t75.c2", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        step();
        chk_out("t75.c3", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // 100 - 60: quarter, dime, nickel
        start_txn(8'd100, 8'd60);
        chk_out("t100.c1", 1'b1, COIN_QUARTER, 1'b1, 1'b0, 1'b0, 8'd40);
        step();
        chk_out("t100.c2", 1'b1, COIN_DIME, 1'b1, 1'b0, 1'b0, 8'd15);
        step();
        chk_out("t100.c3", 1'b1, COIN_NICKEL, 1'b1, 1'b0, 1'b0, 8'd5);
        step();
        chk_out("t100.c4", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        step();
        chk_out("t100.c5", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
`ifdef SODA_COIN_COUNT_EN
        chk("t100.cnt", 32'(bus.coin_cnt), 32'd3);
`endif

        // exact payment: done without coins
        start_txn(8'd50, 8'd50);
        chk_out("t50.c1", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        step();
        chk_out("t50.c2", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // underpayment: err pulse only
        start_txn(8'd30, 8'd50);
        chk_out("t30.c1", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd0);
        step();
        chk_out("t30.c2", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // 63 - 50 with ejector stalled cycles 1-3; start while busy ignored
        bus.coin_rdy = 1'b0;
        start_txn(8'd63, 8'd50);
        bus.start = 1'b1;
        bus.tot   = 8'd10;
        bus.s     = 8'd90;
        chk_out("t63.c1", 1'b1, COIN_DIME, 1'b1, 1'b0, 1'b0, 8'd13);
        step();
        chk_out("t63.c2", 1'b1, COIN_DIME, 1'b1, 1'b0, 1'b0, 8'd13);
        step();
        chk_out("t63.c3", 1'b1, COIN_DIME, 1'b1, 1'b0, 1'b0, 8'd13);
        step();
        bus.start    = 1'b0;
        bus.coin_rdy = 1'b1;
        chk_out("t63.c4", 1'b1, COIN_DIME, 1'b1, 1'b0, 1'b0, 8'd13);
        step();
        chk_out("t63.c5", 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'd3);
`ifdef SODA_COIN_COUNT_EN
        chk("t63.cnt", 32'(bus.coin_cnt), 32'd1);
`endif
        step();
        chk_out("t63.c6", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd3);

        // residue-only change: no coin, done with err
        start_txn(8'd53, 8'd50);
        chk_out("t53.c1", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd3);
        step();
        chk_out("t53.c2", 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'd3);
        step();
        chk_out("t53.c3", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd3);

        // reset during cycle 2 of a 40-cent transaction
        start_txn(8'd90, 8'd50);
        chk_out("rst.c1", 1'b1, COIN_QUARTER, 1'b1, 1'b0, 1'b0, 8'd40);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("rst.c3", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
`ifdef SODA_COIN_COUNT_EN
        chk("rst.cnt", 32'(bus.coin_cnt), 32'd0);
`endif
        start_txn(8'd90, 8'd50);
        chk_out("post.c1", 1'b1, COIN_QUARTER, 1'b1, 1'b0, 1'b0, 8'd40);
        step();
        chk_out("post.c2", 1'b1, COIN_DIME, 1'b1, 1'b0, 1'b0, 8'd15);
        step();
        chk_out("post.c3", 1'b1, COIN_NICKEL, 1'b1, 1'b0, 1'b0, 8'd5);
        step();
        chk_out("post.c4", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
`ifdef SODA_COIN_COUNT_EN
        chk("post.cnt", 32'(bus.coin_cnt), 32'd3);
`endif
        step();
        chk_out("post.c5", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
